seq_controller: RTL

SEQ_CONTROLLER -- requirements
Module: seq_controller

---
 rtl/veririsc_pkg.sv | 45 ++++
 rtl/phase_decode.sv | 69 ++++++
 rtl/seq_controller.sv | 116 +++++++++++
 3 files changed

// File: rtl/veririsc_pkg.sv
// Shared phase encodings, opcode constants and datapath control bundle for the sequencer.
// Latency: n/a (types, constants and a pure combinational helper only).
// Backpressure: n/a.
package veririsc_pkg;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    // Opcodes are held as 32-bit constants so that a zero-extended opcode of any
    // width compares at its full width; values above JMP never match and act as NOPs.
    localparam logic [31:0] OP_HLT = 32'd0;
    localparam logic [31:0] OP_SKZ = 32'd1;
    localparam logic [31:0] OP_ADD = 32'd2;
    localparam logic [31:0] OP_AND = 32'd3;
    localparam logic [31:0] OP_XOR = 32'd4;
    localparam logic [31:0] OP_LDA = 32'd5;
    localparam logic [31:0] OP_STO = 32'd6;
    localparam logic [31:0] OP_JMP = 32'd7;

    typedef struct packed {
        logic sel;
        logic rd;
        logic ld_ir;
        logic halt;
        logic inc_pc;
        logic ld_ac;
        logic ld_pc;
        logic wr;
        logic data_e;
    } ctrl_t;

    // Instructions that read an operand from memory and load the accumulator.
    function automatic logic is_aluop(input logic [31:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/phase_decode.sv
// Purpose: phase/opcode to raw datapath control table.
// Latency: purely combinational, zero cycles.
// Backpressure: none; gating for halt/error/pause is applied by the parent.
module phase_decode
    import veririsc_pkg::*;
#(
    parameter int OPC_W = 3
) (
    input  phase_t           phase,
    input  logic [OPC_W-1:0] op_code,
    input  logic             zero,
    output ctrl_t            ctrl
);

    logic [31:0] op_ext;
    logic        aluop;
    logic        op_hlt;
    logic        op_skz;
    logic        op_sto;
    logic        op_jmp;

    assign op_ext = 32'(op_code);
    assign aluop  = is_aluop(op_ext);
    assign op_hlt = (op_ext == OP_HLT);
    assign op_skz = (op_ext == OP_SKZ);
    assign op_sto = (op_ext == OP_STO);
    assign op_jmp = (op_ext == OP_JMP);

    // Control table: each phase raises only the strobes it needs, everything else low.
    always_comb begin
        ctrl = '0;
        case (phase)
            INST_ADDR: begin
                ctrl.sel = 1'b1;
            end
            INST_FETCH: begin
                ctrl.sel = 1'b1;
                ctrl.rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
                ctrl.sel   = 1'b1;
                ctrl.rd    = 1'b1;
                ctrl.ld_ir = 1'b1;
            end
            OP_ADDR: begin
                ctrl.inc_pc = 1'b1;
                ctrl.halt   = op_hlt;
            end
            OP_FETCH: begin
                ctrl.rd = aluop;
            end
            ALU_OP: begin
                ctrl.rd     = aluop;
                ctrl.inc_pc = op_skz & zero;
                ctrl.ld_pc  = op_jmp;
                ctrl.data_e = op_sto;
            end
            STORE: begin
                ctrl.rd     = aluop;
                ctrl.ld_ac  = aluop;
                ctrl.ld_pc  = op_jmp;
                ctrl.data_e = op_sto;
                ctrl.wr     = op_sto;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/seq_controller.sv
// Purpose: eight-phase instruction sequencer with halt, single-step pause and memory-timeout error.
// Latency: controls are combinational from the phase register; phase advances one step per cycle.
// Backpressure: mem_ready=0 in an instruction/operand fetch holds the phase; WAIT_MAX+1 stalled cycles raise sticky err.
module seq_controller
    import veririsc_pkg::*;
#(
    parameter int OPC_W    = 3,
    parameter int WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             en,
    input  logic             zero,
    input  logic [OPC_W-1:0] op_code,
    input  logic             mem_ready,
    input  logic             step_mode,
    input  logic             go,
    output logic [2:0]       phase,
    output logic             sel,
    output logic             rd,
    output logic             ld_ir,
    output logic             halt,
    output logic             inc_pc,
    output logic             ld_ac,
    output logic             ld_pc,
    output logic             wr,
    output logic             data_e,
    output logic             halted,
    output logic             err
);

    localparam int WCNT_W = $clog2(WAIT_MAX + 1);

    phase_t              phase_q;
    logic                halted_q;
    logic                err_q;
    logic                paused_q;
    logic [WCNT_W-1:0]   wait_q;

    phase_t              dec_phase;
    ctrl_t               dec;
    logic                active;
    logic                op_hlt;
    logic                stall_phase;

    // While reset is asserted the table sees INST_ADDR so outputs are the phase0 decode
    // even before the first reset edge has cleared the phase register.
    assign dec_phase = rst_ ? phase_q : INST_ADDR;

    phase_decode #(.OPC_W(OPC_W)) u_phase_decode (
        .phase   (dec_phase),
        .op_code (op_code),
        .zero    (zero),
        .ctrl    (dec)
    );

    assign active      = rst_ & en & ~halted_q & ~err_q & ~paused_q;
    assign op_hlt      = (32'(op_code) == OP_HLT);
    assign stall_phase = (phase_q == INST_FETCH) ||
                         ((phase_q == OP_FETCH) && is_aluop(32'(op_code)));

    assign phase  = phase_q;
    assign halted = halted_q;
    assign err    = err_q;
    assign sel    = dec.sel;
    assign rd     = dec.rd     & active;
    assign ld_ir  = dec.ld_ir  & active;
    assign inc_pc = dec.inc_pc & active;
    assign ld_ac  = dec.ld_ac  & active;
    assign ld_pc  = dec.ld_pc  & active;
    assign wr     = dec.wr     & active;
    assign data_e = dec.data_e & active;
    assign halt   = rst_ & (halted_q | (dec.halt & active));

    // Sequencer state: error freezes everything, halt/pause wait for go, otherwise step or stall.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
            paused_q <= 1'b0;
            wait_q   <= '0;
        end else if (err_q) begin
            phase_q <= phase_q;
        end else if (halted_q) begin
            if (go) begin
                halted_q <= 1'b0;
                phase_q  <= OP_FETCH;
                wait_q   <= '0;
            end
        end else if (paused_q) begin
            if (go) begin
                paused_q <= 1'b0;
                phase_q  <= INST_FETCH;
                wait_q   <= '0;
            end
        end else if (en) begin
            if ((phase_q == OP_ADDR) && op_hlt) begin
                halted_q <= 1'b1;
            end else if (stall_phase && !mem_ready) begin
                if (wait_q == WCNT_W'(WAIT_MAX)) begin
                    err_q <= 1'b1;
                end else begin
                    wait_q <= wait_q + 1'b1;
                end
            end else begin
                wait_q  <= '0;
                phase_q <= phase_t'(phase_q + 3'd1);
                if ((phase_q == STORE) && step_mode) begin
                    paused_q <= 1'b1;
                end
            end
        end
    end

endmodule
